weight_bank_ctrl: RTL



---
 rtl/weight_bank_pkg.sv | 35 +++
 rtl/weight_bank_ctrl_if.sv | 31 +++
 rtl/weight_pack_buffer.sv | 50 +++++
 rtl/weight_bank_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/weight_bank_pkg.sv
// Shared types and constants for the weight BRAM controller and its helpers.
package weight_bank_pkg;

  localparam int unsigned WORDS_PER_MAC = 5;
  localparam int unsigned DEF_MAC_NUM   = 256;
  localparam int unsigned WORD_W        = WORDS_PER_MAC * DEF_MAC_NUM;
  localparam int unsigned MAX_KERNEL    = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WFILL,
    ST_WCOMMIT,
    ST_RISSUE,
    ST_RWAIT,
    ST_RVALID,
    ST_DONE
  } state_e;

  function automatic int unsigned word_width(input int unsigned mac_num);
    return WORDS_PER_MAC * mac_num;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/weight_bank_ctrl_if.sv
// Preload stream, MAC read side and multi-port BRAM bundle of the weight bank.
interface weight_bank_ctrl_if #(
  parameter int unsigned WORD_W    = weight_bank_pkg::WORD_W,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned NUM_PORTS = 2
) ();
  logic [WORD_W-1:0]           s_data;
  logic                        s_valid;
  logic                        s_ready;
  logic                        rd_req;
  logic [2:0]                  rd_words;
  logic [NUM_PORTS*WORD_W-1:0] rd_data;
  logic                        rd_valid;
  logic [NUM_PORTS-1:0]        bram_en;
  logic [NUM_PORTS-1:0]        bram_we;
  logic [NUM_PORTS*ADDR_W-1:0] bram_addr;
  logic [NUM_PORTS*WORD_W-1:0] bram_wdata;
  logic [NUM_PORTS*WORD_W-1:0] bram_rdata;

  // Controller side
  modport master (
    input  s_data, s_valid, rd_req, rd_words, bram_rdata,
    output s_ready, rd_data, rd_valid, bram_en, bram_we, bram_addr, bram_wdata
  );

  // Environment side (FIFO, MAC array, BRAM)
  modport slave (
    output s_data, s_valid, rd_req, rd_words, bram_rdata,
    input  s_ready, rd_data, rd_valid, bram_en, bram_we, bram_addr, bram_wdata
  );
endinterface

// File: rtl/weight_pack_buffer.sv
// Collects streamed words into per-port slots until a pack is complete.
module weight_pack_buffer #(
  parameter int unsigned WORD_W    = 1280,
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned CNT_W     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        wr_en,
  input  logic [CNT_W-1:0]            need,
  input  logic [WORD_W-1:0]           wr_data,
  output logic [NUM_PORTS*WORD_W-1:0] slots,
  output logic [CNT_W-1:0]            fill,
  output logic                        flush
);

  logic [NUM_PORTS*WORD_W-1:0] slots_q, slots_d;
  logic [CNT_W-1:0]            fill_q, fill_d;

  // Store the incoming word in the next free slot; flush when the pack is complete
  always_comb begin
    slots_d = slots_q;
    fill_d  = fill_q;
    flush   = wr_en && ((fill_q + CNT_W'(1)) == need);
    if (clear) begin
      fill_d = '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (fill_q == CNT_W'(i)) slots_d[i*WORD_W +: WORD_W] = wr_data;
      end
      fill_d = fill_q + CNT_W'(1);
    end
  end

  // Slot and fill-count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      slots_q <= '0;
      fill_q  <= '0;
    end else begin
      slots_q <= slots_d;
      fill_q  <= fill_d;
    end
  end

  assign slots = slots_q;
  assign fill  = fill_q;

endmodule

// File: rtl/weight_bank_ctrl.sv
// Multi-port weight BRAM controller: packed preload writes and multi-word reads.
module weight_bank_ctrl
  import weight_bank_pkg::*;
#(
  parameter int unsigned MAC_NUM   = 256,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned OC_W      = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic              cfg_write,
  input  logic [2:0]        cfg_kernel_size,
  input  logic [OC_W-1:0]   cfg_out_ch,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  weight_bank_ctrl_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned DW    = word_width(MAC_NUM);
  localparam int unsigned TOT_W = OC_W + 3;
  localparam int unsigned CNT_W = clog2(NUM_PORTS + 1);
  localparam int unsigned LAT_W = (clog2(RD_LAT + 1) > 0) ? clog2(RD_LAT + 1) : 1;
  localparam int unsigned CHK_W = ((ADDR_W > TOT_W) ? ADDR_W : TOT_W) + 1;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       cur_q, cur_d;
  logic [TOT_W-1:0]        rem_q, rem_d;
  logic [LAT_W-1:0]        lat_q, lat_d;
  logic [NUM_PORTS-1:0]    rmask_q, rmask_d;
  logic [NUM_PORTS*DW-1:0] rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic [TOT_W-1:0]        total;
  logic [CHK_W-1:0]        span, limit;
  logic                    start_bad;
  logic [NUM_PORTS-1:0]    issue_mask;
  logic [TOT_W-1:0]        rd_n;
  logic [CNT_W-1:0]        pb_need, pb_fill;
  logic                    pb_clear, pb_wr, pb_flush;
  logic [NUM_PORTS*DW-1:0] pb_slots;

  weight_pack_buffer #(
    .WORD_W    (DW),
    .NUM_PORTS (NUM_PORTS),
    .CNT_W     (CNT_W)
  ) u_pack (
    .clk     (clk),
    .rst     (rst),
    .clear   (pb_clear),
    .wr_en   (pb_wr),
    .need    (pb_need),
    .wr_data (bus.s_data),
    .slots   (pb_slots),
    .fill    (pb_fill),
    .flush   (pb_flush)
  );

  // Job length, start validation, per-pack target and read step size
  always_comb begin
    total     = {3'b000, cfg_out_ch} * {{OC_W{1'b0}}, cfg_kernel_size};
    span      = CHK_W'(cfg_base_addr) + CHK_W'(total);
    limit     = '0;
    limit[ADDR_W] = 1'b1;
    start_bad = (cfg_kernel_size == 3'd0) || (cfg_kernel_size > 3'(MAX_KERNEL)) ||
                (total == '0) || (span > limit);
    pb_need   = (rem_q < TOT_W'(NUM_PORTS)) ? CNT_W'(rem_q) : CNT_W'(NUM_PORTS);
    rd_n      = (TOT_W'(bus.rd_words) < rem_q) ? TOT_W'(bus.rd_words) : rem_q;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      // cur+i < end is equivalent to i < remaining, so no end address is kept
      issue_mask[i] = TOT_W'(i) < rem_q;
    end
  end

  // Next-state and datapath updates; abort overrides every state
  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    rem_d    = rem_q;
    lat_d    = lat_q;
    rmask_d  = rmask_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    pb_clear = 1'b0;
    pb_wr    = 1'b0;
    if (cfg_abort) begin
      state_d  = ST_IDLE;
      pb_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_start) begin
            if (start_bad) begin
              err_d = 1'b1;
            end else begin
              cur_d   = cfg_base_addr;
              rem_d   = total;
              state_d = cfg_write ? ST_WFILL : ST_RISSUE;
            end
          end
        end
        ST_WFILL: begin
          pb_wr = bus.s_valid;
          if (pb_flush) state_d = ST_WCOMMIT;
        end
        ST_WCOMMIT: begin
          pb_clear = 1'b1;
          cur_d    = cur_q + ADDR_W'(pb_fill);
          rem_d    = rem_q - TOT_W'(pb_fill);
          state_d  = (rem_q == TOT_W'(pb_fill)) ? ST_DONE : ST_WFILL;
        end
        ST_RISSUE: begin
          rmask_d = issue_mask;
          lat_d   = '0;
          state_d = ST_RWAIT;
        end
        ST_RWAIT: begin
          if (lat_q == LAT_W'(RD_LAT - 1)) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
              rdata_d[i*DW +: DW] = rmask_q[i] ? bus.bram_rdata[i*DW +: DW] : '0;
            end
            state_d = ST_RVALID;
          end else begin
            lat_d = lat_q + LAT_W'(1);
          end
        end
        ST_RVALID: begin
          if (bus.rd_req && (bus.rd_words != 3'd0)) begin
            cur_d   = cur_q + ADDR_W'(rd_n);
            rem_d   = rem_q - rd_n;
            state_d = (rem_q == rd_n) ? ST_DONE : ST_RISSUE;
          end
        end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Control and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
      rmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
      rmask_q <= rmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // BRAM port drive; unused ports idle at zero and abort drops enables at once
  always_comb begin
    bus.bram_en    = '0;
    bus.bram_we    = '0;
    bus.bram_addr  = '0;
    bus.bram_wdata = '0;
    if (!cfg_abort) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if ((state_q == ST_WCOMMIT) && (CNT_W'(i) < pb_fill)) begin
          bus.bram_en[i]                 = 1'b1;
          bus.bram_we[i]                 = 1'b1;
          bus.bram_addr[i*ADDR_W +: ADDR_W] = cur_q + ADDR_W'(i);
          bus.bram_wdata[i*DW +: DW]     = pb_slots[i*DW +: DW];
        end else if ((state_q == ST_RISSUE) && issue_mask[i]) begin
          bus.bram_en[i]                 = 1'b1;
          bus.bram_addr[i*ADDR_W +: ADDR_W] = cur_q + ADDR_W'(i);
        end
      end
    end
  end

  assign bus.s_ready  = (state_q == ST_WFILL);
  assign bus.rd_valid = (state_q == ST_RVALID);
  assign bus.rd_data  = rdata_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE) && !cfg_abort;
  assign err          = err_q;

endmodule
